pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage that consumes the PCAsrc/PCBsrc redirect selects from the branch decision logic.
- Holds the architectural PC and issues fetch requests to instruction memory with a req/ready handshake.
- Latches the returned instruction and advances the PC when the current instruction retires.
- Sits between branch condition evaluation (upstream selects) and the decode stage (downstream instruction).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, redirect target on misaligned target; used only when PC_TRAP_VECTOR_EN is defined.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- PCAsrc  in  1  offset select: 0 = imm, 1 = +4.
- PCBsrc  in  1  base select: 0 = PC, 1 = rs1.
- imm  in  32  sign-extended branch/jump offset.
- rs1  in  32  register rs1 value (JALR base).
- retire  in  1  current instruction completes this cycle; PC may advance.
- stall  in  1  blocks retire while high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (equals pc_out).
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_out  out  32  latched instruction for decode.
- instr_valid  out  1  instr_out holds a valid instruction.
- pc_out  out  32  current PC.
- pc_plus4  out  32  pc_out + 4, the link value for JAL/JALR.
- misalign_trap  out  1  sticky flag: a target with bits[1:0] != 0 was computed.
- instret  out  32  retired-instruction counter.

Behaviour:
- Reset values (any cycle where rst=1, including mid-fetch):
  - state = RST; pc_out = RESET_PC; instr_out = 0; instr_valid = 0.
  - imem_req = 0; misalign_trap = 0; instret = 0.
  - An imem_ready arriving in a reset cycle is ignored.
- Next-PC arithmetic, 32-bit modulo 2^32 with wrap-around allowed, no carry out:
  - PCAsrc=1: next = PC + 4, and PCBsrc is ignored.
  - PCAsrc=0, PCBsrc=0: next = PC + imm.
  - PCAsrc=0, PCBsrc=1: next = (rs1 + imm) & ~32'h1.
- States:
  - RST: imem_req=0; next cycle go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc_out.
    - If imem_ready: instr_out <= imem_rdata, instr_valid <= 1, go to EXEC.
    - Otherwise hold; there is no timeout.
    - Response latency is 0 or more cycles; imem_ready in the first FETCH cycle is legal.
    - retire and stall are ignored in FETCH.
  - EXEC: imem_req=0; instr_out held stable.
    - If retire & ~stall and next[1:0]==0: pc_out <= next, instret += 1, instr_valid <= 0, go to FETCH.
    - If retire & ~stall and next[1:0]!=0: misalign_trap <= 1, instr_valid <= 0, go to HALT. pc_out and instret are unchanged.
    - If retire & stall: no change.
  - HALT: imem_req=0; stays in HALT until rst.
- Latency:
  - Retire to the next imem_req is 1 cycle.
  - Minimum instruction period is 2 cycles (FETCH with immediate ready, then EXEC with retire).
- Counter and output rules:
  - instret wraps from 32'hFFFF_FFFF to 0.
  - pc_plus4 is combinational from pc_out and wraps the same way.
  - PCAsrc, PCBsrc, imm and rs1 are sampled only in the cycle where retire & ~stall in EXEC.

Optional Feature:
- Macro PC_TRAP_VECTOR_EN.
- Defined:
  - A misaligned target in EXEC sets misalign_trap and loads pc_out <= TRAP_VEC.
  - instret is not incremented; next state is FETCH (no HALT state).
  - misalign_trap stays sticky until rst.
- Undefined: HALT behaviour as described above, and TRAP_VEC is unused.

Test Plan:
- Reset then sequential run:
  - Stimulus: rst 1 cycle; imem_ready=1 on every FETCH cycle; retire=1 on every EXEC cycle; PCAsrc=1.
  - Response: imem_addr = 0x0, 0x4, 0x8, 0xC on successive FETCH cycles; instret reaches 3 after the third retire.
- Taken branch backward:
  - Stimulus: pc=0x10, PCAsrc=0, PCBsrc=0, imm=0xFFFF_FFF8, retire.
  - Response: next fetch addr = 0x08.
- JALR alignment:
  - Stimulus: PCAsrc=0, PCBsrc=1, rs1=0x2001, imm=0x4, retire.
  - Response: fetch addr = 0x2004, pc_plus4 = 0x2008 in the following EXEC.
- Stall and slow memory:
  - Stimulus: imem_ready delayed 3 cycles; then in EXEC, retire=1 with stall=1 for 2 cycles, then stall=0.
  - Response: imem_req high for 4 cycles; pc_out unchanged during stall; advances one cycle after stall drops.
- Misaligned target:
  - Stimulus: PCAsrc=0, PCBsrc=0, pc=0x20, imm=0x6, retire.
  - Response without macro: misalign_trap=1, HALT, imem_req=0 forever, pc_out=0x20.
  - Response with PC_TRAP_VECTOR_EN: fetch addr = 0x100.
- Reset mid-fetch:
  - Stimulus: rst asserted in FETCH with imem_ready=1 in the same cycle.
  - Response: instr_valid=0, pc_out=RESET_PC, imem_req=0 for one cycle, then refetch at 0x0.
- Wrap-around:
  - Stimulus: pc=0xFFFF_FFFC, PCAsrc=1, retire.
  - Response: next fetch addr = 0x0.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch channel: request/address out, ready/data back.
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch FSM driven by PCAsrc/PCBsrc redirect selects.
// Optional macro PC_TRAP_VECTOR_EN: misaligned targets redirect to TRAP_VEC instead of halting.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCAsrc,
  input  logic        PCBsrc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        retire,
  input  logic        stall,
  pc_fetch_if.master  imem,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        misalign_trap,
  output logic [31:0] instret
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              trap_q, trap_d;
  logic [XLEN-1:0]   instret_q, instret_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   next_pc;
  logic              commit;

`ifndef PC_TRAP_VECTOR_EN
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
`endif

  // Redirect target; JALR clears bit 0 only, so bit 1 can still misalign.
  always_comb begin
    next_pc = XLEN'(pc_q + XLEN'(4));
    if (!PCAsrc) begin
      if (PCBsrc) next_pc = XLEN'(rs1 + imm) & ~XLEN'(1);
      else        next_pc = XLEN'(pc_q + imm);
    end
  end

  assign commit = (state_q == EXEC) && retire && !stall;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    trap_d    = trap_q;
    instret_d = instret_q;
    unique case (state_q)
      RST:   state_d = FETCH;
      FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (commit) begin
          valid_d = 1'b0;
          if (next_pc[1:0] == 2'b00) begin
            pc_d      = next_pc;
            instret_d = XLEN'(instret_q + XLEN'(1));
            state_d   = FETCH;
          end else begin
            trap_d = 1'b1;
`ifdef PC_TRAP_VECTOR_EN
            pc_d    = TRAP_VEC;
            state_d = FETCH;
`else
            state_d = HALT;
`endif
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RST;
    endcase
    req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      trap_q    <= 1'b0;
      instret_q <= '0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      trap_q    <= trap_d;
      instret_q <= instret_d;
      req_q     <= req_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_out      = instr_q;
  assign instr_valid    = valid_q;
  assign pc_out         = pc_q;
  assign pc_plus4       = XLEN'(pc_q + XLEN'(4));
  assign misalign_trap  = trap_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit with a transaction-level PC/instret model.
module tb_pc_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        PCAsrc, PCBsrc, retire, stall;
  logic [31:0] imm, rs1;
  logic [31:0] instr_out, pc_out, pc_plus4, instret;
  logic        instr_valid, misalign_trap;

  pc_fetch_if bus ();

  pc_fetch_unit #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst), .PCAsrc(PCAsrc), .PCBsrc(PCBsrc), .imm(imm), .rs1(rs1),
    .retire(retire), .stall(stall), .imem(bus), .instr_out(instr_out),
    .instr_valid(instr_valid), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .misalign_trap(misalign_trap), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp = 0;
  int err = 0;
  logic [31:0] m_pc, m_instret;
  logic        m_trap;

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic a, input logic b,
                                           input logic [31:0] im, input logic [31:0] r1);
    if (a) return pc + 32'd4;
    if (!b) return pc + im;
    return (r1 + im) & 32'hFFFF_FFFE;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset;
    m_pc = RESET_PC; m_instret = 32'd0; m_trap = 1'b0;
  endtask

  task automatic wait_req;
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin tick(); n++; end
    cmp++; if (bus.imem_req !== 1'b1) begin err++; $display("FAIL req_timeout got=%b exp=1", bus.imem_req); end
  endtask

  // One full instruction: fetch with dly wait cycles, stl stalled retire cycles, then commit.
  task automatic do_instr(input int dly, input int stl, input logic a, input logic b,
                          input logic [31:0] im, input logic [31:0] r1);
    logic [31:0] nxt, word;
    int reqs;
    wait_req();
    cmp++; if (bus.imem_addr !== m_pc) begin err++; $display("FAIL fetch_addr got=%h exp=%h", bus.imem_addr, m_pc); end
    cmp++; if (instr_valid !== 1'b0) begin err++; $display("FAIL fetch_valid got=%b exp=0", instr_valid); end
    reqs = 0;
    for (int k = 0; k < dly; k++) begin
      bus.imem_ready = 1'b0; retire = 1'($urandom); stall = 1'($urandom);
      if (bus.imem_req === 1'b1) reqs++;
      tick();
    end
    word = $urandom;
    bus.imem_ready = 1'b1; bus.imem_rdata = word; retire = 1'($urandom); stall = 1'b0;
    if (bus.imem_req === 1'b1) reqs++;
    tick();
    bus.imem_ready = 1'b0; bus.imem_rdata = $urandom; retire = 1'b0;
    cmp++; if (reqs != dly + 1) begin err++; $display("FAIL req_cycles got=%0d exp=%0d", reqs, dly + 1); end
    cmp++; if (bus.imem_req !== 1'b0) begin err++; $display("FAIL exec_req got=%b exp=0", bus.imem_req); end
    cmp++; if (instr_valid !== 1'b1) begin err++; $display("FAIL exec_valid got=%b exp=1", instr_valid); end
    cmp++; if (instr_out !== word) begin err++; $display("FAIL instr_out got=%h exp=%h", instr_out, word); end
    cmp++; if (pc_plus4 !== m_pc + 32'd4) begin err++; $display("FAIL pc_plus4 got=%h exp=%h", pc_plus4, m_pc + 32'd4); end
    cmp++; if (instret !== m_instret) begin err++; $display("FAIL exec_instret got=%h exp=%h", instret, m_instret); end
    for (int k = 0; k < stl; k++) begin
      retire = 1'b1; stall = 1'b1; PCAsrc = 1'($urandom); PCBsrc = 1'($urandom); imm = $urandom; rs1 = $urandom;
      tick();
      cmp++; if (pc_out !== m_pc) begin err++; $display("FAIL stall_pc got=%h exp=%h", pc_out, m_pc); end
      cmp++; if (instr_valid !== 1'b1 || instr_out !== word) begin err++; $display("FAIL stall_instr got=%b/%h exp=1/%h", instr_valid, instr_out, word); end
      cmp++; if (bus.imem_req !== 1'b0) begin err++; $display("FAIL stall_req got=%b exp=0", bus.imem_req); end
    end
    retire = 1'b1; stall = 1'b0; PCAsrc = a; PCBsrc = b; imm = im; rs1 = r1;
    nxt = ref_next(m_pc, a, b, im, r1);
    tick();
    retire = 1'b0; PCAsrc = 1'($urandom); PCBsrc = 1'($urandom); imm = $urandom; rs1 = $urandom;
    if (nxt[1:0] == 2'b00) begin
      m_pc = nxt; m_instret = m_instret + 32'd1;
      cmp++; if (bus.imem_req !== 1'b1) begin err++; $display("FAIL retire_req got=%b exp=1", bus.imem_req); end
    end else begin
      m_trap = 1'b1;
`ifdef PC_TRAP_VECTOR_EN
      m_pc = TRAP_VEC;
      cmp++; if (bus.imem_req !== 1'b1) begin err++; $display("FAIL trapvec_req got=%b exp=1", bus.imem_req); end
`else
      cmp++; if (bus.imem_req !== 1'b0) begin err++; $display("FAIL halt_req got=%b exp=0", bus.imem_req); end
`endif
    end
    cmp++; if (pc_out !== m_pc) begin err++; $display("FAIL retire_pc got=%h exp=%h", pc_out, m_pc); end
    cmp++; if (instret !== m_instret) begin err++; $display("FAIL retire_instret got=%h exp=%h", instret, m_instret); end
    cmp++; if (instr_valid !== 1'b0) begin err++; $display("FAIL retire_valid got=%b exp=0", instr_valid); end
    cmp++; if (misalign_trap !== m_trap) begin err++; $display("FAIL trap_flag got=%b exp=%b", misalign_trap, m_trap); end
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.imem_ready = 1'b1; bus.imem_rdata = $urandom;
    tick(); tick();
    cmp++; if (bus.imem_req !== 1'b0) begin err++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
    cmp++; if (pc_out !== RESET_PC) begin err++; $display("FAIL rst_pc got=%h exp=%h", pc_out, RESET_PC); end
    cmp++; if (instr_out !== 32'd0 || instr_valid !== 1'b0) begin err++; $display("FAIL rst_instr got=%h/%b exp=0/0", instr_out, instr_valid); end
    cmp++; if (misalign_trap !== 1'b0 || instret !== 32'd0) begin err++; $display("FAIL rst_trap_instret got=%b/%h exp=0/0", misalign_trap, instret); end
    rst = 1'b0; bus.imem_ready = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 4; i++) begin
      wait_req();
      cmp++; if (bus.imem_addr !== 32'(4 * i)) begin err++; $display("FAIL seq_addr got=%h exp=%h", bus.imem_addr, 32'(4 * i)); end
      do_instr(0, 0, 1'b1, 1'b0, 32'd0, 32'd0);
      if (i == 2) begin
        cmp++; if (instret !== 32'd3) begin err++; $display("FAIL seq_instret got=%0d exp=3", instret); end
      end
    end
  endtask

  task automatic test_branch_back;
    do_instr(0, 0, 1'b0, 1'b1, 32'd0, 32'h10);
    do_instr(1, 0, 1'b0, 1'b0, 32'hFFFF_FFF8, $urandom);
    wait_req();
    cmp++; if (bus.imem_addr !== 32'h08) begin err++; $display("FAIL branch_back got=%h exp=00000008", bus.imem_addr); end
  endtask

  task automatic test_jalr;
    do_instr(0, 0, 1'b0, 1'b1, 32'h4, 32'h2001);
    wait_req();
    cmp++; if (bus.imem_addr !== 32'h2004) begin err++; $display("FAIL jalr_addr got=%h exp=00002004", bus.imem_addr); end
    do_instr(0, 0, 1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_stall_slow;
    do_instr(3, 2, 1'b1, 1'b1, $urandom, $urandom);
  endtask

  task automatic test_wrap;
    do_instr(0, 0, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFC);
    do_instr(0, 0, 1'b1, 1'b0, 32'd0, 32'd0);
    wait_req();
    cmp++; if (bus.imem_addr !== 32'h0) begin err++; $display("FAIL wrap_addr got=%h exp=00000000", bus.imem_addr); end
  endtask

  task automatic test_random;
    logic [31:0] im, r1;
    for (int i = 0; i < 40; i++) begin
      im = $urandom & 32'hFFFF_FFFC;
      r1 = $urandom & 32'hFFFF_FFFD;
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), im, r1);
    end
  endtask

  task automatic test_misalign;
    do_instr(0, 0, 1'b0, 1'b1, 32'd0, 32'h20);
    do_instr(0, 0, 1'b0, 1'b0, 32'h6, $urandom);
`ifdef PC_TRAP_VECTOR_EN
    wait_req();
    cmp++; if (bus.imem_addr !== 32'h100) begin err++; $display("FAIL trapvec_addr got=%h exp=00000100", bus.imem_addr); end
    do_instr(0, 0, 1'b1, 1'b0, 32'd0, 32'd0);
    cmp++; if (misalign_trap !== 1'b1) begin err++; $display("FAIL trap_sticky got=%b exp=1", misalign_trap); end
`else
    for (int k = 0; k < 6; k++) begin
      bus.imem_ready = 1'($urandom); retire = 1'($urandom);
      tick();
      cmp++; if (bus.imem_req !== 1'b0 || pc_out !== 32'h20) begin err++; $display("FAIL halt_hold got=%b/%h exp=0/00000020", bus.imem_req, pc_out); end
      cmp++; if (misalign_trap !== 1'b1 || instr_valid !== 1'b0) begin err++; $display("FAIL halt_flags got=%b/%b exp=1/0", misalign_trap, instr_valid); end
    end
    bus.imem_ready = 1'b0; retire = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_fetch;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    cmp++; if (bus.imem_req !== 1'b1) begin err++; $display("FAIL mid_pre_req got=%b exp=1", bus.imem_req); end
    rst = 1'b1; bus.imem_ready = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0; bus.imem_ready = 1'b0;
    cmp++; if (instr_valid !== 1'b0 || instr_out !== 32'd0) begin err++; $display("FAIL mid_instr got=%b/%h exp=0/0", instr_valid, instr_out); end
    cmp++; if (bus.imem_req !== 1'b0 || pc_out !== RESET_PC) begin err++; $display("FAIL mid_req_pc got=%b/%h exp=0/%h", bus.imem_req, pc_out, RESET_PC); end
    cmp++; if (misalign_trap !== 1'b0 || instret !== 32'd0) begin err++; $display("FAIL mid_trap_instret got=%b/%h exp=0/0", misalign_trap, instret); end
    tick();
    cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin err++; $display("FAIL mid_refetch got=%b/%h exp=1/00000000", bus.imem_req, bus.imem_addr); end
    model_reset();
    do_instr(0, 0, 1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; PCAsrc = 1'b1; PCBsrc = 1'b0; imm = 32'd0; rs1 = 32'd0;
    retire = 1'b0; stall = 1'b0; bus.imem_ready = 1'b0; bus.imem_rdata = 32'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch_back();
    test_jalr();
    test_stall_slow();
    test_wrap();
    test_random();
    test_misalign();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
